// File: rtl/rtr_route_req_sched_pkg.sv
// Constants shared by the route-request scheduler and its arbiter:
// FSM state encoding and the bit positions of the route-filter error flags.
package rtr_route_req_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BACKOFF = 2'd2
  } sched_state_e;

  localparam int ERR_W         = 2;
  localparam int ERR_BAD_PORT  = 0;
  localparam int ERR_BAD_CLASS = 1;

  localparam int WAIT_W        = 8;
  localparam int ERR_CNT_W     = 8;
  localparam int ERR_CNT_MAX   = 255;

endpackage

// File: rtl/rtr_rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping around.
// Bit i of req/gnt is requester i; gnt is one-hot or zero.
module rtr_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [PTR_W-1:0] idx;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = PTR_W'((int'(ptr) + off) % N);
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtr_route_req_sched.sv
// Per-input-port route request scheduler: picks a VC with a filtered route,
// flushes it on route errors, otherwise requests the VC allocator with timeout.
module rtr_route_req_sched
  import rtr_route_req_sched_pkg::*;
#(
  parameter int num_vcs              = 4,
  parameter int num_ports            = 5,
  parameter int num_resource_classes = 2,
  parameter int max_wait             = 15
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [num_vcs-1:0]                     vc_route_valid,
  input  logic [num_vcs*num_ports-1:0]           vc_route_op,
  input  logic [num_vcs*num_resource_classes-1:0] vc_route_orc,
  input  logic [num_vcs*ERR_W-1:0]               vc_route_err,
  output logic                                   req_valid,
  input  logic                                   req_ready,
  output logic [num_vcs-1:0]                     req_vc,
  output logic [num_ports-1:0]                   req_op,
  output logic [num_resource_classes-1:0]        req_orc,
  output logic [num_vcs-1:0]                     vc_done,
  output logic [num_vcs-1:0]                     vc_flush,
  output logic [ERR_CNT_W-1:0]                   err_count,
  output logic [ERR_W-1:0]                       err_sticky
);

  localparam int PTR_W = (num_vcs > 1) ? $clog2(num_vcs) : 1;

  // Port vectors carry VC 0 in the most-significant slice; internally VC i is index i.
  logic [num_vcs-1:0]              valid_idx;
  logic [num_ports-1:0]            op_idx  [num_vcs];
  logic [num_resource_classes-1:0] orc_idx [num_vcs];
  logic [ERR_W-1:0]                err_idx [num_vcs];
  logic [num_vcs-1:0]              done_idx, flush_idx;

  sched_state_e                    state_q, state_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [PTR_W-1:0]                vc_q, vc_d;
  logic [WAIT_W-1:0]               wait_q, wait_d;
  logic [num_ports-1:0]            op_q, op_d;
  logic [num_resource_classes-1:0] orc_q, orc_d;
  logic [ERR_CNT_W-1:0]            err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0]                err_sticky_q, err_sticky_d;

  logic [num_vcs-1:0]              gnt;
  logic [PTR_W-1:0]                gnt_idx;
  logic                            gnt_any;
  logic [ERR_W-1:0]                gnt_err;
  logic                            in_req;

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (int'(idx) == num_vcs - 1) ? '0 : idx + PTR_W'(1);
  endfunction

  for (genvar i = 0; i < num_vcs; i++) begin : g_vc
    assign valid_idx[i] = vc_route_valid[num_vcs-1-i];
    assign op_idx[i]    = vc_route_op[(num_vcs-1-i)*num_ports +: num_ports];
    assign orc_idx[i]   = vc_route_orc[(num_vcs-1-i)*num_resource_classes +: num_resource_classes];
    assign err_idx[i]   = vc_route_err[(num_vcs-1-i)*ERR_W +: ERR_W];

    assign req_vc[num_vcs-1-i]   = in_req && (int'(vc_q) == i);
    assign vc_done[num_vcs-1-i]  = done_idx[i];
    // Flush is decided combinationally in IDLE, so it must be masked while reset is held.
    assign vc_flush[num_vcs-1-i] = flush_idx[i] & reset;
  end

  // One arbiter serves both flush and request selection.
  rtr_rr_pick #(.N(num_vcs), .PTR_W(PTR_W)) u_pick (
    .req     (valid_idx),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign gnt_err = err_idx[gnt_idx];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    vc_d         = vc_q;
    wait_d       = wait_q;
    op_d         = op_q;
    orc_d        = orc_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    done_idx     = '0;
    flush_idx    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          if (gnt_err[ERR_BAD_PORT] || gnt_err[ERR_BAD_CLASS]) begin
            flush_idx    = gnt;
            err_sticky_d = err_sticky_q | gnt_err;
            ptr_d        = ptr_after(gnt_idx);
            if (err_cnt_q != ERR_CNT_W'(ERR_CNT_MAX)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end else begin
            vc_d    = gnt_idx;
            op_d    = op_idx[gnt_idx];
            orc_d   = orc_idx[gnt_idx];
            wait_d  = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Priority: handshake, then the VC withdrawing its route, then timeout.
        if (req_ready) begin
          done_idx[vc_q] = 1'b1;
          ptr_d          = ptr_after(vc_q);
          state_d        = ST_IDLE;
        end else if (!valid_idx[vc_q]) begin
          state_d = ST_IDLE;
        end else if (int'(wait_q) >= max_wait - 1) begin
          ptr_d   = ptr_after(vc_q);
          state_d = ST_BACKOFF;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_BACKOFF: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      vc_q         <= '0;
      wait_q       <= '0;
      op_q         <= '0;
      orc_q        <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      vc_q         <= vc_d;
      wait_q       <= wait_d;
      op_q         <= op_d;
      orc_q        <= orc_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign in_req     = (state_q == ST_REQ);
  assign req_valid  = in_req;
  assign req_op     = in_req ? op_q  : '0;
  assign req_orc    = in_req ? orc_q : '0;
  assign err_count  = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule
